// File: rtl/ctr_gain_multi_ch.sv
// ctr_gain_multi_ch: multi-channel signed gain controller for the signal
// generator front panel. It holds one saturating gain register per channel.
// Three debounced-by-sync buttons select the channel, select the step
// (+1, +2, -1, -2) and apply the step. The adjust button auto-repeats
// while it is held.
//
// Ports
//   i_clk       single clock
//   i_rst       synchronous active-high reset
//   i_btn_ch    raw channel-select button (active-low, async)
//   i_btn_step  raw step-select button (active-low, async)
//   i_btn_adj   raw adjust button (active-low, async)
//   i_en        adjust enable
//   o_gain      packed signed gains, channel c at [c*GAIN_W +: GAIN_W]
//   o_ch_sel    selected channel
//   o_sat       one-cycle pulse when an adjustment was clamped
//   o_hex_0..3  active-low gfedcba digits: step magnitude, step sign,
//               selected gain magnitude, selected gain sign
module ctr_gain_multi_ch #(
  parameter int NUM_CH     = 4,
  parameter int GAIN_W     = 4,
  parameter int GAIN_RST   = 1,
  parameter int HOLD_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000,
  parameter int NUM_SEG    = 7,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_btn_ch,
  input  logic                     i_btn_step,
  input  logic                     i_btn_adj,
  input  logic                     i_en,
  output logic [NUM_CH*GAIN_W-1:0] o_gain,
  output logic [CH_W-1:0]          o_ch_sel,
  output logic                     o_sat,
  output logic [NUM_SEG-1:0]       o_hex_0,
  output logic [NUM_SEG-1:0]       o_hex_1,
  output logic [NUM_SEG-1:0]       o_hex_2,
  output logic [NUM_SEG-1:0]       o_hex_3
);

  localparam int EXT_W   = GAIN_W + 2;
  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]        HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]        RPT_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic signed [EXT_W-1:0] G_MAX     = EXT_W'((1 << (GAIN_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] G_MIN     = EXT_W'(-(1 << (GAIN_W - 1)));
  localparam logic [NUM_SEG-1:0]      SEG_BLANK = '1;
  localparam logic [NUM_SEG-1:0]      SEG_MINUS = NUM_SEG'(7'b0111111);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RPT} state_t;

  // Button bit order: [2]=adjust, [1]=step, [0]=channel.
  logic [2:0] sync1, sync2, prev;
  logic [2:0] press;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     do_adj;

  logic signed [GAIN_W-1:0] gain [NUM_CH];
  logic [CH_W-1:0]          ch_sel;
  logic [1:0]               step_idx;

  logic signed [GAIN_W-1:0] cur_gain;
  logic signed [EXT_W-1:0]  step_val;
  logic signed [EXT_W-1:0]  sum;
  logic [GAIN_W-1:0]        new_gain;
  logic                     clamp;
  logic [GAIN_W:0]          gain_mag;

  function automatic logic [NUM_SEG-1:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = NUM_SEG'(7'b1000000);
      4'd1:    seg7 = NUM_SEG'(7'b1111001);
      4'd2:    seg7 = NUM_SEG'(7'b0100100);
      4'd3:    seg7 = NUM_SEG'(7'b0110000);
      4'd4:    seg7 = NUM_SEG'(7'b0011001);
      4'd5:    seg7 = NUM_SEG'(7'b0010010);
      4'd6:    seg7 = NUM_SEG'(7'b0000010);
      4'd7:    seg7 = NUM_SEG'(7'b1111000);
      4'd8:    seg7 = NUM_SEG'(7'b0000000);
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Registers reset to released so reset release never looks like a press.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= {i_btn_adj, i_btn_step, i_btn_ch};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press = prev & ~sync2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_adj    = 1'b0;
    case (state)
      S_IDLE: begin
        if (press[2] && i_en) begin
          do_adj    = 1'b1;
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end
      end
      S_HOLD: begin
        if (sync2[2] || !i_en) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          do_adj    = 1'b1;
          state_nxt = S_RPT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RPT: begin
        if (sync2[2] || !i_en) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == RPT_LAST) begin
          do_adj  = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign cur_gain = gain[ch_sel];

  always_comb begin
    case (step_idx)
      2'd0:    step_val = EXT_W'(1);
      2'd1:    step_val = EXT_W'(2);
      2'd2:    step_val = EXT_W'(-1);
      default: step_val = EXT_W'(-2);
    endcase
  end

  // Two guard bits keep the sum exact so clamping compares the true value.
  always_comb begin
    sum      = $signed({{2{cur_gain[GAIN_W-1]}}, cur_gain}) + step_val;
    new_gain = sum[GAIN_W-1:0];
    clamp    = 1'b0;
    if (sum > G_MAX) begin
      new_gain = G_MAX[GAIN_W-1:0];
      clamp    = 1'b1;
    end else if (sum < G_MIN) begin
      new_gain = G_MIN[GAIN_W-1:0];
      clamp    = 1'b1;
    end
  end

  // The adjustment sees the old channel and step; both update on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) gain[c] <= GAIN_W'(GAIN_RST);
      ch_sel   <= '0;
      step_idx <= '0;
      o_sat    <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (do_adj && (ch_sel == CH_W'(c))) gain[c] <= new_gain;
      end
      o_sat <= do_adj & clamp;
      if (press[0]) ch_sel <= (ch_sel == CH_W'(NUM_CH - 1)) ? '0 : ch_sel + 1'b1;
      if (press[1]) step_idx <= step_idx + 2'd1;
    end
  end

  always_comb begin
    o_gain = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) o_gain[c*GAIN_W +: GAIN_W] = gain[c];
  end

  assign o_ch_sel = ch_sel;

  // Widened by one bit so the most negative gain has a representable magnitude.
  always_comb begin
    gain_mag = cur_gain[GAIN_W-1] ? -{cur_gain[GAIN_W-1], cur_gain}
                                  :  {cur_gain[GAIN_W-1], cur_gain};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_hex_0 <= SEG_BLANK;
      o_hex_1 <= SEG_BLANK;
      o_hex_2 <= SEG_BLANK;
      o_hex_3 <= SEG_BLANK;
    end else begin
      o_hex_0 <= seg7(step_idx[0] ? 4'd2 : 4'd1);
      o_hex_1 <= step_idx[1] ? SEG_MINUS : SEG_BLANK;
      o_hex_2 <= seg7(4'(gain_mag));
      o_hex_3 <= cur_gain[GAIN_W-1] ? SEG_MINUS : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_ctr_gain_multi_ch.sv
// Bench for ctr_gain_multi_ch with short hold/repeat times. A negedge monitor
// records every o_gain change and o_sat cycle. Stimulus tasks push the
// expected {cycle, gains} entries, and each test drains and compares both queues.
module tb_ctr_gain_multi_ch;
  localparam int NUM_CH = 4;
  localparam int GAIN_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_ch = 1'b1, btn_step = 1'b1, btn_adj = 1'b1, en = 1'b1;
  logic [15:0] o_gain;
  logic [1:0]  o_ch_sel;
  logic        o_sat;
  logic [6:0]  o_hex_0, o_hex_1, o_hex_2, o_hex_3;

  ctr_gain_multi_ch #(
    .NUM_CH(NUM_CH), .GAIN_W(GAIN_W), .GAIN_RST(1),
    .HOLD_CYC(10), .REPEAT_CYC(4), .NUM_SEG(7)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_btn_ch(btn_ch), .i_btn_step(btn_step),
    .i_btn_adj(btn_adj), .i_en(en), .o_gain(o_gain), .o_ch_sel(o_ch_sel),
    .o_sat(o_sat), .o_hex_0(o_hex_0), .o_hex_1(o_hex_1),
    .o_hex_2(o_hex_2), .o_hex_3(o_hex_3)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [47:0] exp_q[$], obs_q[$];
  int unsigned sat_exp_q[$], sat_obs_q[$];
  logic        mon_en = 1'b0;
  logic [15:0] last_gain;

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_gain !== last_gain) obs_q.push_back({cyc, o_gain});
      if (o_sat === 1'b1) sat_obs_q.push_back(cyc);
    end
    last_gain <= o_gain;
  end

  int m_gain[NUM_CH];
  int m_ch, m_step;
  int total = 0, bad = 0;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      default: return BLANK;
    endcase
  endfunction

  function automatic int step_val(input int idx);
    case (idx)
      0: return 1;  1: return 2;  2: return -1;
      default: return -2;
    endcase
  endfunction

  function automatic logic [15:0] pack_model();
    logic [15:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*4 +: 4] = 4'(m_gain[c]);
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) m_gain[c] = 1;
    m_ch = 0;
    m_step = 0;
  endtask

  // Drive the selected buttons low together for 'hold' cycles and predict the result.
  task automatic press(input bit ch, input bit st, input bit adj, input int hold);
    int unsigned t;
    int nxt;
    @(negedge clk);
    t = cyc;
    if (ch)  btn_ch = 1'b0;
    if (st)  btn_step = 1'b0;
    if (adj) btn_adj = 1'b0;
    if (adj && en) begin
      nxt = m_gain[m_ch] + step_val(m_step);
      if (nxt > 7) begin
        nxt = 7;
        sat_exp_q.push_back(32'(t + 3));
      end else if (nxt < -8) begin
        nxt = -8;
        sat_exp_q.push_back(32'(t + 3));
      end
      if (nxt != m_gain[m_ch]) begin
        m_gain[m_ch] = nxt;
        exp_q.push_back({32'(t + 3), pack_model()});
      end
    end
    if (ch) m_ch = (m_ch + 1) % NUM_CH;
    if (st) m_step = (m_step + 1) % 4;
    repeat (hold) @(negedge clk);
    btn_ch = 1'b1;
    btn_step = 1'b1;
    btn_adj = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    btn_ch = 1'b1;
    btn_step = 1'b1;
    btn_adj = 1'b1;
    en = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    sat_exp_q.delete();
    sat_obs_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (o_gain !== 16'h1111) begin bad++; $display("FAIL reset_gain: got %h want 1111", o_gain); end
    total++; if (o_ch_sel !== 2'd0) begin bad++; $display("FAIL reset_ch: got %0d want 0", o_ch_sel); end
    total++; if (o_sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b want 0", o_sat); end
    total++;
    if ({o_hex_3, o_hex_2, o_hex_1, o_hex_0} !== {4{BLANK}}) begin
      bad++; $display("FAIL reset_hex: got %b %b %b %b want all blank", o_hex_3, o_hex_2, o_hex_1, o_hex_0);
    end
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL reset_release: %0d gain changes, want 0", obs_q.size()); end
    total++;
    if ({o_hex_3, o_hex_2, o_hex_1, o_hex_0} !== {BLANK, seg(1), BLANK, seg(1)}) begin
      bad++; $display("FAIL reset_disp: got %b %b %b %b", o_hex_3, o_hex_2, o_hex_1, o_hex_0);
    end
    obs_q.delete();
  endtask

  task automatic test_single_adjust();
    int unsigned t;
    logic [47:0] e, o;
    @(negedge clk);
    t = cyc;
    btn_adj = 1'b0;
    m_gain[0] = 2;
    exp_q.push_back({32'(t + 3), 16'h1112});
    @(negedge clk);
    btn_adj = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (o_gain !== 16'h1112) begin bad++; $display("FAIL single_gain_k2: got %h want 1112", o_gain); end
    total++; if (o_hex_2 !== seg(1)) begin bad++; $display("FAIL single_hex_lag: got %b want %b", o_hex_2, seg(1)); end
    @(negedge clk);
    total++; if (o_hex_2 !== seg(2)) begin bad++; $display("FAIL single_hex2: got %b want %b", o_hex_2, seg(2)); end
    total++; if (o_hex_3 !== BLANK) begin bad++; $display("FAIL single_hex3: got %b want %b", o_hex_3, BLANK); end
    repeat (4) @(negedge clk);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
      total++;
      if (o !== e) begin bad++; $display("FAIL single_seq: got cyc=%0d gain=%h want cyc=%0d gain=%h", o[47:16], o[15:0], e[47:16], e[15:0]); end
    end
  endtask

  task automatic test_neg_step();
    logic [47:0] e, o;
    apply_reset();
    repeat (3) press(0, 1, 0, 1);
    total++; if (o_hex_1 !== MINUS) begin bad++; $display("FAIL negstep_hex1: got %b want %b", o_hex_1, MINUS); end
    total++; if (o_hex_0 !== seg(2)) begin bad++; $display("FAIL negstep_hex0: got %b want %b", o_hex_0, seg(2)); end
    repeat (3) press(0, 0, 1, 1);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
      total++;
      if (o !== e) begin bad++; $display("FAIL negstep_seq: got cyc=%0d gain=%h want cyc=%0d gain=%h", o[47:16], o[15:0], e[47:16], e[15:0]); end
    end
    total++; if (o_gain !== 16'h111B) begin bad++; $display("FAIL negstep_gain: got %h want 111b", o_gain); end
    total++; if (o_hex_3 !== MINUS) begin bad++; $display("FAIL negstep_hex3: got %b want %b", o_hex_3, MINUS); end
    total++; if (o_hex_2 !== seg(5)) begin bad++; $display("FAIL negstep_hex2: got %b want %b", o_hex_2, seg(5)); end
  endtask

  task automatic test_saturation();
    logic [47:0] e, o;
    int unsigned se, so;
    press(0, 0, 1, 1);               // -5 - 2 = -7
    press(0, 0, 1, 1);               // -9 clamps to -8
    repeat (3) press(0, 1, 0, 1);    // step -1
    press(0, 0, 1, 1);               // already at -8
    total++; if (o_hex_2 !== seg(8)) begin bad++; $display("FAIL sat_hex2: got %b want %b", o_hex_2, seg(8)); end
    total++; if (o_hex_3 !== MINUS) begin bad++; $display("FAIL sat_hex3: got %b want %b", o_hex_3, MINUS); end
    press(1, 0, 0, 1);               // channel 1
    repeat (3) press(0, 1, 0, 1);    // step +2
    repeat (3) press(0, 0, 1, 1);    // 3, 5, 7
    press(0, 0, 1, 1);               // already at 7
    total++; if (o_gain !== 16'h1178) begin bad++; $display("FAIL sat_gain: got %h want 1178", o_gain); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
      total++;
      if (o !== e) begin bad++; $display("FAIL sat_seq: got cyc=%0d gain=%h want cyc=%0d gain=%h", o[47:16], o[15:0], e[47:16], e[15:0]); end
    end
    while (sat_exp_q.size() != 0 || sat_obs_q.size() != 0) begin
      se = (sat_exp_q.size() != 0) ? sat_exp_q.pop_front() : 0;
      so = (sat_obs_q.size() != 0) ? sat_obs_q.pop_front() : 0;
      total++;
      if (so !== se) begin bad++; $display("FAIL sat_pulse: got o_sat at cyc=%0d want cyc=%0d", so, se); end
    end
  endtask

  task automatic test_auto_repeat();
    int unsigned t;
    int offs[6] = '{3, 13, 17, 21, 25, 29};
    logic [47:0] e, o;
    apply_reset();
    repeat (2) press(0, 1, 0, 1);    // step -1
    @(negedge clk);
    t = cyc;
    btn_adj = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m_gain[0] = m_gain[0] - 1;
      exp_q.push_back({32'(t + offs[i]), pack_model()});
    end
    repeat (30) @(negedge clk);
    btn_adj = 1'b1;
    repeat (20) @(negedge clk);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
      total++;
      if (o !== e) begin bad++; $display("FAIL repeat_seq: got cyc=%0d gain=%h want cyc=%0d gain=%h", o[47:16], o[15:0], e[47:16], e[15:0]); end
    end
    total++; if (o_gain !== 16'h111B) begin bad++; $display("FAIL repeat_final: got %h want 111b", o_gain); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] e, o;
    apply_reset();
    press(1, 0, 0, 1);
    total++; if (o_ch_sel !== 2'd1) begin bad++; $display("FAIL b2b_ch1: got %0d want 1", o_ch_sel); end
    press(1, 0, 1, 1);               // adjusts ch1, then selects ch2
    total++; if (o_ch_sel !== 2'd2) begin bad++; $display("FAIL b2b_ch2: got %0d want 2", o_ch_sel); end
    press(0, 1, 1, 1);               // adjusts ch2 with +1, then step becomes +2
    total++; if (o_hex_0 !== seg(2)) begin bad++; $display("FAIL b2b_step: got %b want %b", o_hex_0, seg(2)); end
    total++; if (o_gain !== 16'h1221) begin bad++; $display("FAIL b2b_gain: got %h want 1221", o_gain); end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
      total++;
      if (o !== e) begin bad++; $display("FAIL b2b_seq: got cyc=%0d gain=%h want cyc=%0d gain=%h", o[47:16], o[15:0], e[47:16], e[15:0]); end
    end
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      press(1, 0, 0, 1);
      total++;
      if (o_ch_sel !== 2'(i % NUM_CH)) begin bad++; $display("FAIL ch_wrap: got %0d want %0d", o_ch_sel, i % NUM_CH); end
    end
  endtask

  task automatic test_enable();
    apply_reset();
    en = 1'b0;
    press(1, 0, 0, 1);
    total++; if (o_ch_sel !== 2'd1) begin bad++; $display("FAIL en_ch: got %0d want 1", o_ch_sel); end
    press(0, 1, 0, 1);
    total++; if (o_hex_0 !== seg(2)) begin bad++; $display("FAIL en_step: got %b want %b", o_hex_0, seg(2)); end
    @(negedge clk);
    btn_adj = 1'b0;
    repeat (15) @(negedge clk);
    en = 1'b1;                       // no new falling edge, so still idle
    repeat (20) @(negedge clk);
    btn_adj = 1'b1;
    repeat (6) @(negedge clk);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL en_changes: got %0d gain changes want 0", obs_q.size()); end
    total++; if (o_gain !== 16'h1111) begin bad++; $display("FAIL en_gain: got %h want 1111", o_gain); end
  endtask

  task automatic test_reset_mid_repeat();
    int unsigned t;
    int offs[3] = '{3, 13, 17};
    logic [47:0] e, o;
    apply_reset();
    press(1, 0, 0, 1);               // channel 1
    repeat (2) press(0, 1, 0, 1);    // step -1
    @(negedge clk);
    t = cyc;
    btn_adj = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_gain[1] = m_gain[1] - 1;
      exp_q.push_back({32'(t + offs[i]), pack_model()});
    end
    repeat (19) @(negedge clk);
    rst = 1'b1;
    btn_adj = 1'b1;
    model_reset();
    exp_q.push_back({32'(t + 20), 16'h1111});
    @(negedge clk);
    total++; if (o_gain !== 16'h1111) begin bad++; $display("FAIL midrst_gain: got %h want 1111", o_gain); end
    total++; if (o_ch_sel !== 2'd0) begin bad++; $display("FAIL midrst_ch: got %0d want 0", o_ch_sel); end
    total++; if (o_sat !== 1'b0) begin bad++; $display("FAIL midrst_sat: got %b want 0", o_sat); end
    total++;
    if ({o_hex_3, o_hex_2, o_hex_1, o_hex_0} !== {4{BLANK}}) begin
      bad++; $display("FAIL midrst_hex: got %b %b %b %b want all blank", o_hex_3, o_hex_2, o_hex_1, o_hex_0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
      total++;
      if (o !== e) begin bad++; $display("FAIL midrst_seq: got cyc=%0d gain=%h want cyc=%0d gain=%h", o[47:16], o[15:0], e[47:16], e[15:0]); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_adjust();
    test_neg_step();
    test_saturation();
    test_auto_repeat();
    test_back_to_back();
    test_enable();
    test_reset_mid_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
